exibe_resultado: RTL
====================

Name: exibe_resultado

Overview:
- Downstream consumer of the 16-bit system result (`saida` from the result register).
- Converts the unsigned value to 5 BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Drives a 5-digit, time-multiplexed, common-anode seven-segment display.
- Lets the ALU/multiplication result (0..65535) be shown in decimal on the board.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit-scan step (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- dado  input  16  unsigned value to display (result register output).
- dado_valido  input  1  one-cycle strobe; dado is valid this cycle.
- ocupado  output  1  high while a conversion is in progress or one is pending.
- pronto  output  1  one-cycle pulse when bcd is updated.
- bcd  output  20  last converted value; [19:16]=ten-thousands … [3:0]=units.
- seg  output  7  segments, active-low; seg[6]=g … seg[0]=a.
- an  output  5  digit enables, active-low one-hot; an[0]=units.

Behaviour:
- Single clock domain. Reset is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - State OCIOSO, pending flag 0.
  - bcd=0, pronto=0, ocupado=0.
  - Scan counter 0, digit index 0.
  - an=5'b11110, seg=7'b1000000 (digit "0").
- Reset asserted mid-conversion aborts the conversion. The pending value is discarded, and no pronto is issued.
- Internal 36-bit shift register: {bcd20, bin16}. 4-bit shift counter.
- FSM states:
  - OCIOSO:
    - dado_valido=1 loads shreg={20'b0,dado} and clears the counter. Go to DESLOCA.
    - Otherwise stay.
  - DESLOCA:
    - Each edge, add 3 to every BCD nibble ≥5, then shift the whole register left by 1.
    - Counter increments.
    - The edge performing the 16th shift moves to CONCLUI.
  - CONCLUI:
    - bcd<=shreg[35:16]; pronto=1 for exactly the following cycle.
    - If the pending flag is set: load the pending value, clear the flag, go to DESLOCA (no idle cycle).
    - Otherwise go to OCIOSO.
- Latency:
  - Sample edge E0; shifts on E1..E16; bcd updated and pronto high after E17. Total 17 clocks.
  - Back-to-back conversions: 17 clocks each.
- dado_valido while not OCIOSO (including CONCLUI) captures dado into a pending register and sets the pending flag.
  - A later strobe overwrites the pending value (newest wins; intermediate values are dropped).
  - The current conversion is never disturbed.
- Strobe in the same cycle as CONCLUI with no prior pending: the strobe becomes pending and starts next via the CONCLUI rule.
- ocupado = (state≠OCIOSO) | pending.
- bcd holds its value between conversions. The display always shows bcd, never partial shift-register contents.
- Scan:
  - The counter counts 0..SCAN_DIV-1; the terminal count produces a tick and wraps to 0.
  - The tick advances the digit index 0→1→2→3→4→0.
  - an and seg are registered and change on the tick edge. They are consistent: both reflect the same index.
- Decode table, seg[6:0]:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Nibbles >9 are unreachable, but must decode to "-" = 0111111.

Optional Feature:
- Macro: EXIBE_APAGA_ZEROS_EN.
- Defined: leading-zero blanking.
  - A digit above the most-significant nonzero digit is driven seg=7'b1111111 while its an is still scanned.
  - The units digit is never blanked, so value 0 shows a single "0".
- Not defined: all 5 digits are always shown, including leading zeros.

Test Plan:
- Reset, then dado=16'd1234 with a strobe at E0 → pronto high exactly after E17; bcd=20'h01234; ocupado high E0..E17, low after.
- dado=65535 → bcd=20'h65535. dado=0 → bcd=20'h00000. dado=9 → bcd=20'h00009 (nibble-correction boundaries).
- Strobe 100, then strobe 200 at E5 and 300 at E9 → first pronto with bcd=20'h00100, second pronto 17 clocks later with bcd=20'h00300; 200 never appears; exactly two pronto pulses.
- rst_n=0 at E8 of converting 4321 → bcd=0, pronto never pulses, ocupado=0, an=11110, seg=1000000 the cycle after reset.
- SCAN_DIV=4, bcd=20'h01234:
  - an steps 11110→11101→11011→10111→01111→11110, one step every 4 clocks.
  - seg shows 4,3,2,1,0 in that order.
  - With EXIBE_APAGA_ZEROS_EN, the ten-thousands digit shows seg=1111111.

Source files
------------

// File: rtl/exibe_resultado_if.sv
// Result-display bus: value strobe in, conversion status and BCD out.
interface exibe_resultado_if;
  logic [15:0] dado;
  logic        dado_valido;
  logic        ocupado;
  logic        pronto;
  logic [19:0] bcd;

  modport master (
    output dado,
    output dado_valido,
    input  ocupado,
    input  pronto,
    input  bcd
  );

  modport slave (
    input  dado,
    input  dado_valido,
    output ocupado,
    output pronto,
    output bcd
  );
endinterface

// File: rtl/exibe_resultado.sv
// 16-bit binary to 5-digit BCD (double-dabble) with a muxed 7-seg scan.
// Define EXIBE_APAGA_ZEROS_EN to blank leading zero digits.
module exibe_resultado #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  exibe_resultado_if.slave    bus,
  output logic [6:0]          seg,
  output logic [4:0]          an
);

  typedef enum logic [1:0] {
    OCIOSO,
    DESLOCA,
    CONCLUI
  } estado_t;

  localparam int CW = $clog2(SCAN_DIV);

  estado_t     estado, estado_nxt;
  logic [35:0] shreg, shreg_nxt, adj;
  logic [3:0]  cnt, cnt_nxt;
  logic        pend, pend_nxt;
  logic [15:0] pend_val, pend_val_nxt;
  logic [19:0] bcd, bcd_nxt;
  logic        pronto, pronto_nxt;

  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx, idx_nxt;
  logic          tick;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_nxt;
  logic [4:0]    an_nxt;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  endfunction

  // add-3 correction on every BCD nibble before the shift
  always_comb begin
    adj = shreg;
    for (int i = 0; i < 5; i++) begin
      if (shreg[16+4*i +: 4] >= 4'd5)
        adj[16+4*i +: 4] = shreg[16+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    estado_nxt   = estado;
    shreg_nxt    = shreg;
    cnt_nxt      = cnt;
    pend_nxt     = pend;
    pend_val_nxt = pend_val;
    bcd_nxt      = bcd;
    pronto_nxt   = 1'b0;
    case (estado)
      OCIOSO: begin
        if (bus.dado_valido) begin
          shreg_nxt  = {20'b0, bus.dado};
          cnt_nxt    = 4'd0;
          estado_nxt = DESLOCA;
        end
      end
      DESLOCA: begin
        shreg_nxt = adj << 1;
        cnt_nxt   = cnt + 4'd1;
        if (cnt == 4'd15)
          estado_nxt = CONCLUI;
        if (bus.dado_valido) begin
          pend_nxt     = 1'b1;
          pend_val_nxt = bus.dado;
        end
      end
      CONCLUI: begin
        bcd_nxt    = shreg[35:16];
        pronto_nxt = 1'b1;
        cnt_nxt    = 4'd0;
        pend_nxt   = 1'b0;
        // a strobe landing now is newer than any held value
        if (bus.dado_valido) begin
          shreg_nxt  = {20'b0, bus.dado};
          estado_nxt = DESLOCA;
        end else if (pend) begin
          shreg_nxt  = {20'b0, pend_val};
          estado_nxt = DESLOCA;
        end else begin
          estado_nxt = OCIOSO;
        end
      end
      default: begin
        estado_nxt = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado   <= OCIOSO;
      shreg    <= '0;
      cnt      <= '0;
      pend     <= 1'b0;
      pend_val <= '0;
      bcd      <= '0;
      pronto   <= 1'b0;
    end else begin
      estado   <= estado_nxt;
      shreg    <= shreg_nxt;
      cnt      <= cnt_nxt;
      pend     <= pend_nxt;
      pend_val <= pend_val_nxt;
      bcd      <= bcd_nxt;
      pronto   <= pronto_nxt;
    end
  end

  assign bus.bcd     = bcd;
  assign bus.pronto  = pronto;
  assign bus.ocupado = (estado != OCIOSO) | pend;

  assign tick    = (scan_cnt == CW'(SCAN_DIV - 1));
  assign idx_nxt = (idx == 3'd4) ? 3'd0 : idx + 3'd1;

  always_comb begin
    nib = bcd[{idx_nxt, 2'b00} +: 4];
`ifdef EXIBE_APAGA_ZEROS_EN
    blank = (idx_nxt != 3'd0) &&
            ((bcd >> {idx_nxt, 2'b00}) == 20'd0);
`else
    blank = 1'b0;
`endif
    seg_nxt = blank ? 7'b1111111 : dec(nib);
    an_nxt  = ~(5'b00001 << idx_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= 5'b11110;
      seg      <= 7'b1000000;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + CW'(1);
      if (tick) begin
        idx <= idx_nxt;
        an  <= an_nxt;
        seg <= seg_nxt;
      end
    end
  end

endmodule
